seq_mult_n: RTL and testbench

SEQ_MULT_N -- requirements
Module: seq_mult_n

---
 rtl/seq_mult_pkg.sv | 14 +
 rtl/mult_addsub.sv | 13 +
 rtl/seq_mult_n.sv | 141 ++++++++++++++
 tb/tb_seq_mult_n.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_mult_pkg.sv
// Shared types and limits for the sequential signed multiplier.
package seq_mult_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ADD,
      SHIFT,
      DONE
   } state_t;

   localparam int WIDTH_MIN = 2;
   localparam int WIDTH_MAX = 32;

endpackage

// File: rtl/mult_addsub.sv
// WIDTH+1-bit adder/subtractor for the partial-product step.
module mult_addsub #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH:0] a_i,
   input  logic [WIDTH:0] b_i,
   input  logic           sub_i,
   output logic [WIDTH:0] y_o
);

   assign y_o = sub_i ? (a_i - b_i) : (a_i + b_i);

endmodule

// File: rtl/seq_mult_n.sv
// Sequential signed shift-add multiplier; result in {X,A,B}.
// Define SEQ_MULT_OVF_EN to register a signed-overflow flag on Ovf.
module seq_mult_n
   import seq_mult_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             Clk,
   input  logic             Reset,
   input  logic             Clear_Ld,
   input  logic             Start,
   input  logic [WIDTH-1:0] Din,
   output logic             X,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             Busy,
   output logic             Done,
   output logic             Ovf
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
      $error("seq_mult_n: WIDTH out of range");
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   state_t             state_q;
   logic               x_q;
   logic [WIDTH-1:0]   a_q;
   logic [WIDTH-1:0]   b_q;
   logic [WIDTH-1:0]   s_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH:0]     add_d;
   logic               sh_x;
   logic [WIDTH-1:0]   sh_a;
   logic [WIDTH-1:0]   sh_b;
   logic               last;

   assign last = (cnt_q == CNT_LAST);

   // Final step subtracts: the MSB of B carries negative weight.
   mult_addsub #(.WIDTH(WIDTH)) u_addsub (
      .a_i   ({a_q[WIDTH-1], a_q}),
      .b_i   ({s_q[WIDTH-1], s_q}),
      .sub_i (last),
      .y_o   (add_d)
   );

   assign sh_x = x_q;
   assign sh_a = {x_q, a_q[WIDTH-1:1]};
   assign sh_b = {a_q[0], b_q[WIDTH-1:1]};

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q <= IDLE;
         x_q     <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         s_q     <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (Clear_Ld) begin
                  x_q <= 1'b0;
                  a_q <= '0;
                  b_q <= Din;
               end else if (Start) begin
                  s_q     <= Din;
                  x_q     <= 1'b0;
                  a_q     <= '0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ADD;
               end
            end
            ADD: begin
               if (b_q[0]) begin
                  {x_q, a_q} <= add_d;
               end
               state_q <= SHIFT;
            end
            SHIFT: begin
               x_q   <= sh_x;
               a_q   <= sh_a;
               b_q   <= sh_b;
               cnt_q <= cnt_q + CNT_W'(1);
               if (last) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end else begin
                  state_q <= ADD;
               end
            end
            DONE: begin
               if (!Start) begin
                  done_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

`ifdef SEQ_MULT_OVF_EN
   logic ovf_q;
   logic fits;

   // Product fits WIDTH signed bits when X, A and B's MSB all match.
   assign fits = (sh_a == {WIDTH{sh_x}}) && (sh_b[WIDTH-1] == sh_x);

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         ovf_q <= 1'b0;
      end else if (state_q == IDLE && !Clear_Ld && Start) begin
         ovf_q <= 1'b0;
      end else if (state_q == SHIFT && last) begin
         ovf_q <= !fits;
      end
   end

   assign Ovf = ovf_q;
`else
   assign Ovf = 1'b0;
`endif

   assign X    = x_q;
   assign A    = a_q;
   assign B    = b_q;
   assign Busy = busy_q;
   assign Done = done_q;

endmodule

// File: tb/tb_seq_mult_n.sv
// Directed bench for seq_mult_n at WIDTH=8 and WIDTH=4.
module tb_seq_mult_n;

`ifdef SEQ_MULT_OVF_EN
   localparam bit OVF_ON = 1'b1;
`else
   localparam bit OVF_ON = 1'b0;
`endif

   logic       Clk;
   logic       Reset;

   logic       Clear_Ld, Start;
   logic [7:0] Din;
   logic       X, Busy, Done, Ovf;
   logic [7:0] A, B;

   logic       c4_Clear_Ld, c4_Start;
   logic [3:0] c4_Din;
   logic       c4_X, c4_Busy, c4_Done, c4_Ovf;
   logic [3:0] c4_A, c4_B;

   int n_tests = 0;
   int n_fail  = 0;

   seq_mult_n #(.WIDTH(8)) u8 (
      .Clk      (Clk),
      .Reset    (Reset),
      .Clear_Ld (Clear_Ld),
      .Start    (Start),
      .Din      (Din),
      .X        (X),
      .A        (A),
      .B        (B),
      .Busy     (Busy),
      .Done     (Done),
      .Ovf      (Ovf)
   );

   seq_mult_n #(.WIDTH(4)) u4 (
      .Clk      (Clk),
      .Reset    (Reset),
      .Clear_Ld (c4_Clear_Ld),
      .Start    (c4_Start),
      .Din      (c4_Din),
      .X        (c4_X),
      .A        (c4_A),
      .B        (c4_B),
      .Busy     (c4_Busy),
      .Done     (c4_Done),
      .Ovf      (c4_Ovf)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run8(input string tag, input logic [7:0] bv,
                       input logic [7:0] sv, input logic [7:0] ea,
                       input logic [7:0] eb, input logic ex,
                       input logic eo, input int hold);
      int k;
      int nb;
      @(negedge Clk);
      Clear_Ld = 1'b1;
      Din      = bv;
      @(negedge Clk);
      Clear_Ld = 1'b0;
      Start    = 1'b1;
      Din      = sv;
      @(posedge Clk);
      #1;
      check({tag, "_ovf_clr"}, Ovf, 0);
      Din      = ~sv;
      Clear_Ld = 1'b1;
      k  = 0;
      nb = 0;
      while (!Done && k < 100) begin
         if (Busy) nb++;
         @(posedge Clk);
         #1;
         k++;
      end
      Clear_Ld = 1'b0;
      check({tag, "_lat"}, k, 16);
      check({tag, "_busy"}, nb, 16);
      check({tag, "_x"}, X, ex);
      check({tag, "_a"}, A, ea);
      check({tag, "_b"}, B, eb);
      check({tag, "_ovf"}, Ovf, eo & OVF_ON);
      if (hold > 0) begin
         repeat (hold) @(posedge Clk);
         #1;
         check({tag, "_hold"}, {Done, Busy, X, A, B}, {1'b1, 1'b0, ex, ea, eb});
      end
      Start = 1'b0;
      @(posedge Clk);
      #1;
      check({tag, "_idle"}, {Done, Busy, X, A, B}, {1'b0, 1'b0, ex, ea, eb});
   endtask

   task automatic run4(input string tag, input logic [3:0] bv,
                       input logic [3:0] sv, input logic [3:0] ea,
                       input logic [3:0] eb, input logic ex);
      int k;
      @(negedge Clk);
      c4_Clear_Ld = 1'b1;
      c4_Din      = bv;
      @(negedge Clk);
      c4_Clear_Ld = 1'b0;
      c4_Start    = 1'b1;
      c4_Din      = sv;
      @(posedge Clk);
      #1;
      c4_Din = 4'h0;
      k = 0;
      while (!c4_Done && k < 100) begin
         @(posedge Clk);
         #1;
         k++;
      end
      check({tag, "_lat"}, k, 8);
      check({tag, "_xab"}, {c4_X, c4_A, c4_B}, {ex, ea, eb});
      c4_Start = 1'b0;
      @(posedge Clk);
      #1;
      check({tag, "_idle"}, c4_Done, 0);
   endtask

   initial begin
      int nd;
      Reset       = 1'b0;
      Clear_Ld    = 1'b0;
      Start       = 1'b0;
      Din         = 8'h00;
      c4_Clear_Ld = 1'b0;
      c4_Start    = 1'b0;
      c4_Din      = 4'h0;
      #12;
      check("rst8", {X, A, B, Busy, Done, Ovf}, 0);
      check("rst4", {c4_X, c4_A, c4_B, c4_Busy, c4_Done, c4_Ovf}, 0);
      @(negedge Clk);
      Reset = 1'b1;

      // Clear_Ld wins over a simultaneous Start
      @(negedge Clk);
      Clear_Ld = 1'b1;
      Start    = 1'b1;
      Din      = 8'h33;
      @(negedge Clk);
      check("prio", {Busy, X, A, B}, {1'b0, 1'b0, 8'h00, 8'h33});
      Clear_Ld = 1'b0;
      Start    = 1'b0;

      run8("m7x3",   8'h07, 8'h03, 8'h00, 8'h15, 1'b0, 1'b0, 0);
      run8("m2xm1",  8'h02, 8'hFF, 8'hFF, 8'hFE, 1'b1, 1'b0, 0);
      run8("mneg",   8'h80, 8'h80, 8'h40, 8'h00, 1'b0, 1'b1, 20);
      run8("mm1x7f", 8'hFF, 8'h7F, 8'hFF, 8'h81, 1'b1, 1'b0, 0);
      run8("m7fx7f", 8'h7F, 8'h7F, 8'h3F, 8'h01, 1'b0, 1'b1, 3);
      run8("m10xm10", 8'h0A, 8'hF6, 8'hFF, 8'h9C, 1'b1, 1'b0, 0);

      run4("w4a", 4'h9, 4'h7, 4'hC, 4'hF, 1'b1);
      run4("w4b", 4'h8, 4'h8, 4'h4, 4'h0, 1'b0);

      // Reset during the 5th busy cycle
      @(negedge Clk);
      Clear_Ld = 1'b1;
      Din      = 8'h55;
      @(negedge Clk);
      Clear_Ld = 1'b0;
      Start    = 1'b1;
      Din      = 8'h03;
      @(posedge Clk);
      #1;
      Start = 1'b0;
      repeat (4) @(posedge Clk);
      #1;
      check("rst_busy", Busy, 1);
      #2;
      Reset = 1'b0;
      #1;
      check("rst_mid", {X, A, B, Busy, Done, Ovf}, 0);
      @(negedge Clk);
      Reset = 1'b1;
      nd = 0;
      repeat (40) begin
         @(negedge Clk);
         if (Done) nd++;
      end
      check("rst_nodone", nd, 0);

      run8("post_rst", 8'h05, 8'hFD, 8'hFF, 8'hF1, 1'b1, 1'b0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule
